periph_bus: RTL



---
 rtl/periph_bus_pkg.sv | 25 ++
 rtl/periph_bus_if.sv | 26 ++
 rtl/periph_bus_uart_tx.sv | 92 +++++++++
 rtl/periph_bus.sv | 118 +++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus slice: register offsets, TCON bit
// positions and the UART transmitter state encoding.
package periph_bus_pkg;

    localparam logic [7:0] OFS_TH     = 8'h00;
    localparam logic [7:0] OFS_TL     = 8'h04;
    localparam logic [7:0] OFS_TCON   = 8'h08;
    localparam logic [7:0] OFS_LED    = 8'h0C;
    localparam logic [7:0] OFS_SWITCH = 8'h10;
    localparam logic [7:0] OFS_DIGI   = 8'h14;
    localparam logic [7:0] OFS_TXD    = 8'h18;
    localparam logic [7:0] OFS_UCON   = 8'h20;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/periph_bus_if.sv
// Data-memory bus between the CPU MEM stage (master) and the peripheral responder (slave).
interface periph_bus_if;

    logic        MemRd;
    logic        MemWr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output MemRd,
        output MemWr,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  MemRd,
        input  MemWr,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/periph_bus_uart_tx.sv
// 8N1 UART transmitter: a start pulse launches one frame; done pulses on the
// last cycle of the stop bit, the same edge the FSM returns to idle.
module periph_bus_uart_tx
    import periph_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done    = 1'b0;
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d = data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Line level is registered from the next state so txd is glitch-free.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != StIdle);

endmodule

// File: rtl/periph_bus.sv
// Memory-mapped peripheral responder: reload timer with IRQ, LED/7-seg outputs,
// switch input and a UART transmitter behind a 256-byte register window.
module periph_bus
    import periph_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
    input  logic         clk,
    input  logic         reset,
    periph_bus_if.slave  bus,
    input  logic [7:0]   switch,
    output logic [7:0]   led,
    output logic [11:0]  digi,
    output logic         irqout,
    output logic         txd
);

    logic [31:0] th_q, th_d, tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic        tx_done_q, tx_done_d;
    logic        hit, wr, rd, tx_start, tx_busy, tx_pulse;
    logic [7:0]  ofs;
    logic        unused_addr;

    assign hit         = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign ofs         = {bus.addr[7:2], 2'b00};
    assign wr          = bus.MemWr & hit;
    assign rd          = bus.MemRd & hit;
    assign unused_addr = ^bus.addr[1:0];

    // A TXD write while a frame is in flight is dropped entirely.
    assign tx_start = wr && (ofs == OFS_TXD) && !tx_busy;

    always_comb begin
        bus.rdata = 32'h0;
        if (rd) begin
            case (ofs)
                OFS_TH:     bus.rdata = th_q;
                OFS_TL:     bus.rdata = tl_q;
                OFS_TCON:   bus.rdata = {29'h0, tcon_q};
                OFS_LED:    bus.rdata = {24'h0, led_q};
                OFS_SWITCH: bus.rdata = {24'h0, switch};
                OFS_DIGI:   bus.rdata = {20'h0, digi_q};
                OFS_UCON:   bus.rdata = {30'h0, tx_done_q, tx_busy};
                default:    bus.rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        tx_done_d = tx_done_q;
        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        // CPU writes come last so they override the timer's own updates.
        if (wr) begin
            case (ofs)
                OFS_TH:   th_d   = bus.wdata;
                OFS_TL:   tl_d   = bus.wdata;
                OFS_TCON: tcon_d = bus.wdata[2:0];
                OFS_LED:  led_d  = bus.wdata[7:0];
                OFS_DIGI: digi_d = bus.wdata[11:0];
                default:  ;
            endcase
        end
        if (rd && (ofs == OFS_UCON)) tx_done_d = 1'b0;
        if (tx_start)                tx_done_d = 1'b0;
        if (tx_pulse)                tx_done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            tx_done_q <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            tx_done_q <= tx_done_d;
        end
    end

    periph_bus_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .start(tx_start),
        .data (bus.wdata[7:0]),
        .txd  (txd),
        .busy (tx_busy),
        .done (tx_pulse)
    );

    assign led    = led_q;
    assign digi   = digi_q;
    assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule
